conv_kxk_stream: RTL
====================

Name: conv_kxk_stream

Overview:
Streaming 2-D KxK convolution engine, the parametrised successor to the fixed-kernel conv blocks. It takes raster-order pixels with a valid strobe and buffers K-1 image lines internally. It forms a KxK window, multiplies it by a runtime-loadable signed coefficient set, then rounds, shifts and saturates the sum to an output pixel. It sits between the pixel source (file-driven in benches, sensor/DMA in system) and the downstream pooling/threshold stages.

Parameters:
IMG_W, 220, pixels per line (K..1024)
IMG_H, 220, lines per frame (K..1024)
K, 3, kernel size, odd, 3..7
PIX_W, 8, pixel width, unsigned
COEF_W, 8, coefficient width, two's complement
SHIFT_W, 4, width of the normalisation shift field

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pxl_in  in  PIX_W  input pixel
pxl_in_valid  in  1  pxl_in is valid this cycle; always accepted (no backpressure)
coef_we  in  1  coefficient write strobe
coef_addr  in  6  coefficient index, row*K+col, 0..K*K-1
coef_data  in  COEF_W  coefficient value
shift  in  SHIFT_W  right-shift applied to the accumulator; sampled at frame start
pxl_out  out  PIX_W  output pixel
valid  out  1  pxl_out is valid
frame_done  out  1  one-cycle pulse, coincident with the last valid output of a frame
busy  out  1  frame in progress

Behaviour:
- Reset (reset=0, async): col/row counters=0, valid=0, pxl_out=0, frame_done=0, busy=0, pipeline valids cleared. Coefficients are set to identity: centre tap (K/2)*K+K/2=1, all others 0. Line-buffer contents are don't-care.
- Accept: each cycle with pxl_in_valid=1 writes the pixel at (row,col). col increments; on col=IMG_W-1 it wraps to 0 and row increments. On the last pixel (row=IMG_H-1, col=IMG_W-1) both wrap to 0 and busy clears. Cycles with pxl_in_valid=0 leave all counters and windows untouched.
- busy sets on the first accepted pixel of a frame. shift is latched into shift_q on that same cycle.
- Window: K-1 line buffers, each IMG_W deep. Each buffer does one read and one write per accepted pixel. A KxK shift-register window advances one column per accepted pixel.
- Window validity: a window is valid when row>=K-1 and col>=K-1 (valid-only convolution, no padding). Output is (IMG_W-K+1)x(IMG_H-K+1) pixels per frame, raster order.
- Arithmetic: acc = sum of coef[i]*window[i], signed, width ACC_W = PIX_W+COEF_W+clog2(K*K)+1.
  - If shift_q>0: add 1<<(shift_q-1), then arithmetic shift right by shift_q.
  - Clamp to [0, 2^PIX_W-1].
- Latency: fixed 2 cycles from an accepted pixel completing a valid window to valid=1.
  - Stage 1 registers the products.
  - Stage 2 registers the adder tree plus round/shift/clamp.
  - Pipeline is free-running; valid is the delayed window-valid flag.
- frame_done=1 exactly with the output derived from pixel (IMG_H-1, IMG_W-1).
- Coefficient writes are honoured only when busy=0, and take effect for the next frame. While busy=1 they are silently dropped. A write with coef_addr>=K*K is ignored.
- Back-to-back frames: a pixel of frame N+1 may arrive the cycle after the last pixel of frame N. The pipeline drains frame N while frame N+1 fills; the next 2 cycles produce no output for N+1 since row<K-1.
- Reset mid-frame clears all in-flight outputs (no partial valid). The next frame starts at (0,0).

Decomposition:
- Package conv_pkg holds: clog2 function, ACC_W derivation, the identity-centre index constant, and the saturation/rounding function (reused by the pooling blocks).
- One sub-module: conv_line_buffer (single-port-per-side delay line, depth IMG_W, width PIX_W, with enable).
- Window, MAC and counters stay in the top module.

Test Plan:
- IMG_W=IMG_H=8, K=3, reset coefs, ramp pxl_in=row*8+col -> 36 outputs equal the interior input pixels (first = 9); frame_done on the 36th; output 2 cycles after pixel (2,2).
- All coefs=1, shift=3, constant pixel 80 -> every output (720+4)>>3=90.
- All coefs=1, shift=0, constant 200 -> 255 (saturate high); centre=-1, others 0 -> 0 (saturate low).
- Ramp with pxl_in_valid randomly deasserted ~40% -> output sequence identical to the gap-free run; valid never asserted more than 2 cycles after the last accept.
- coef_we while busy=1 with centre=5 -> ignored, identity output for the current frame; same write between frames -> next frame outputs = 5*pixel clamped.
- Assert reset for 1 cycle at pixel 30 -> valid=0 and busy=0 immediately (async), no stray outputs; the following full frame matches the reference model.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution / pooling blocks:
// width derivation, identity-tap index and round/shift/saturate.
package conv_pkg;

  localparam int unsigned ACC_MAX_W = 48;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned acc_width(input int unsigned pix_w,
                                            input int unsigned coef_w,
                                            input int unsigned k);
    return pix_w + coef_w + clog2(k * k) + 1;
  endfunction

  function automatic int unsigned centre_index(input int unsigned k);
    return (k / 2) * k + k / 2;
  endfunction

  // Round-half-up, arithmetic shift right, clamp to [0, 2^pix_w-1].
  function automatic logic [ACC_MAX_W-1:0] round_shift_sat(
      input logic signed [ACC_MAX_W-1:0] acc,
      input int unsigned                 sh,
      input int unsigned                 pix_w);
    logic signed [ACC_MAX_W-1:0] t;
    logic signed [ACC_MAX_W-1:0] maxv;
    t = acc;
    if (sh != 0) t = t + $signed(ACC_MAX_W'(1) << (sh - 1));
    t = t >>> sh;
    maxv = $signed((ACC_MAX_W'(1) << pix_w) - ACC_MAX_W'(1));
    if (t < 0) return '0;
    else if (t > maxv) return $unsigned(maxv);
    else return $unsigned(t);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-line delay: dout is the value written DEPTH enabled cycles ago.
import conv_pkg::*;

module conv_line_buffer #(
  parameter int unsigned DEPTH = 220,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK valid-only convolution with runtime coefficients,
// two-stage pipeline (products, then sum + round/shift/clamp).
import conv_pkg::*;

module conv_kxk_stream #(
  parameter int unsigned IMG_W   = 220,
  parameter int unsigned IMG_H   = 220,
  parameter int unsigned K       = 3,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pxl_in,
  input  logic               pxl_in_valid,
  input  logic               coef_we,
  input  logic [5:0]         coef_addr,
  input  logic [COEF_W-1:0]  coef_data,
  input  logic [SHIFT_W-1:0] shift,
  output logic [PIX_W-1:0]   pxl_out,
  output logic               valid,
  output logic               frame_done,
  output logic               busy
);

  localparam int unsigned KK     = K * K;
  localparam int unsigned ACC_W  = acc_width(PIX_W, COEF_W, K);
  localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
  localparam int unsigned CENTRE = centre_index(K);
  localparam int unsigned CW     = clog2(IMG_W);
  localparam int unsigned RW     = clog2(IMG_H);

  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [SHIFT_W-1:0]         shift_q;
  logic signed [COEF_W-1:0]   coef    [KK];
  logic [PIX_W-1:0]           win     [K][K];
  logic [PIX_W-1:0]           win_nxt [K][K];
  logic [PIX_W-1:0]           lb_out  [K-1];
  logic signed [PROD_W-1:0]   prod    [KK];
  logic signed [ACC_W-1:0]    acc;
  logic [ACC_MAX_W-1:0]       res;
  logic                       accept, last_px, win_ok, v1, last1;

  assign accept  = pxl_in_valid;
  assign last_px = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign win_ok  = accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  // Buffer j holds line row-1-j; chained so each one feeds the next older line.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_first
      conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb (
        .clk(clk), .reset(reset), .en(accept), .din(pxl_in), .dout(lb_out[j]));
    end else begin : g_chain
      conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb (
        .clk(clk), .reset(reset), .en(accept), .din(lb_out[j-1]), .dout(lb_out[j]));
    end
  end

  // Row 0 of the window is the oldest line, column K-1 the newest pixel.
  always_comb begin
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K - 1; c++)
        win_nxt[r][c] = win[r][c+1];
    win_nxt[K-1][K-1] = pxl_in;
    for (int unsigned j = 0; j < K - 1; j++)
      win_nxt[K-2-j][K-1] = lb_out[j];
  end

  always_ff @(posedge clk) begin
    if (accept) win <= win_nxt;
  end

  // Products are taken from the incoming window so the result lands two cycles after the pixel.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < KK; i++)
      prod[i] <= PROD_W'($signed({1'b0, win_nxt[i/K][i%K]})) * PROD_W'(coef[i]);
  end

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < KK; i++)
      acc = acc + ACC_W'(prod[i]);
    res = round_shift_sat(ACC_MAX_W'(acc), 32'(shift_q), PIX_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      shift_q    <= '0;
      v1         <= 1'b0;
      last1      <= 1'b0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      pxl_out    <= '0;
      for (int unsigned i = 0; i < KK; i++)
        if (i == CENTRE) coef[i] <= COEF_W'(1);
        else             coef[i] <= '0;
    end else begin
      if (accept) begin
        if (!busy) shift_q <= shift;
        if (last_px) begin
          col  <= '0;
          row  <= '0;
          busy <= 1'b0;
        end else begin
          busy <= 1'b1;
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
      if (coef_we && !busy)
        for (int unsigned i = 0; i < KK; i++)
          if (coef_addr == 6'(i)) coef[i] <= coef_data;
      v1         <= win_ok;
      last1      <= accept && last_px;
      valid      <= v1;
      frame_done <= last1;
      pxl_out    <= res[PIX_W-1:0];
    end
  end

endmodule
